// File: rtl/fifo_level_sync_pkg.sv
// Shared types for the level-tracking synchronous FIFO.
package fifo_level_sync_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    // Classifies the accepted traffic of one cycle.
    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATAW storage: synchronous write, asynchronous read, no reset.
module fifo_sync_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DATAW = 8,
    localparam int unsigned ADDRW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic [ADDRW-1:0] raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level_sync.sv
// Synchronous FIFO with occupancy level, threshold flags, sticky error flags
// and a selectable first-word-fall-through or registered read stage.
module fifo_level_sync
    import fifo_level_sync_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATAW      = 8,
    parameter int unsigned AFULL_LVL  = DEPTH - 4,
    parameter int unsigned AEMPTY_LVL = 4,
    parameter int unsigned FWFT       = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       we_i,
    input  logic [DATAW-1:0]           dat_i,
    input  logic                       re_i,
    output logic [DATAW-1:0]           dat_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       afull_o,
    output logic                       aempty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int unsigned ADDRW = $clog2(DEPTH);
    localparam int unsigned LVLW  = ADDRW + 1;

    logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]  level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [DATAW-1:0] head_c;
    logic             wr_acc_c;
    logic             rd_acc_c;
    fifo_flags_t      flags_c;

    fifo_sync_ram #(
        .DEPTH (DEPTH),
        .DATAW (DATAW)
    ) u_ram (
        .clk_i (clk_i),
        .we    (wr_acc_c),
        .waddr (wr_ptr_q),
        .wdata (dat_i),
        .raddr (rd_ptr_q),
        .rdata (head_c)
    );

    // Status flags follow the registered level directly.
    always_comb begin
        flags_c.full   = (level_q == LVLW'(DEPTH));
        flags_c.empty  = (level_q == LVLW'(0));
        flags_c.afull  = (level_q >= LVLW'(AFULL_LVL));
        flags_c.aempty = (level_q <= LVLW'(AEMPTY_LVL));
    end

    // A full FIFO still takes a write when the same cycle pops the head.
    assign rd_acc_c = re_i && !flags_c.empty && !flush_i;
    assign wr_acc_c = we_i && (!flags_c.full || rd_acc_c) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr_d = wr_ptr_q + ADDRW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr_d = rd_ptr_q + ADDRW'(1);
            end
            case (fifo_op(wr_acc_c, rd_acc_c))
                OP_PUSH: level_d = level_q + LVLW'(1);
                OP_POP:  level_d = level_q - LVLW'(1);
                default: level_d = level_q;
            endcase
            if (we_i && !wr_acc_c) begin
                ovf_d = 1'b1;
            end
            if (re_i && flags_c.empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dat_o   = head_c;
            assign valid_o = !flags_c.empty;
        end else begin : g_reg
            logic [DATAW-1:0] dat_q;
            logic             valid_q;

            // Flush blocks rd_acc_c, so valid drops and data holds.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    dat_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc_c;
                    if (rd_acc_c) begin
                        dat_q <= head_c;
                    end
                end
            end

            assign dat_o   = dat_q;
            assign valid_o = valid_q;
        end
    endgenerate

    assign full_o   = flags_c.full;
    assign empty_o  = flags_c.empty;
    assign afull_o  = flags_c.afull;
    assign aempty_o = flags_c.aempty;
    assign level_o  = level_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule

// File: tb/tb_fifo_level_sync.sv
// Bench for fifo_level_sync: three configurations checked against a queue model.
module tb_fifo_level_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       we  [3];
    logic       re  [3];
    logic       fl  [3];
    logic [7:0] din [3];

    wire [7:0] dout   [3];
    wire       valid  [3];
    wire       full   [3];
    wire       empty  [3];
    wire       afull  [3];
    wire       aempty [3];
    wire       ovf    [3];
    wire       udf    [3];
    wire [2:0] lvl_a;
    wire [3:0] lvl_b;
    wire [2:0] lvl_c;

    // Reference model: one queue per instance plus the sticky flags and read register.
    logic [7:0] mq [3][$];
    bit         m_ovf [3];
    bit         m_udf [3];
    bit         m_val [3];
    logic [7:0] m_dat [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_level_sync #(.DEPTH(4), .DATAW(8), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(1)) u_d4 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .we_i(we[0]), .dat_i(din[0]), .re_i(re[0]),
        .dat_o(dout[0]), .valid_o(valid[0]), .full_o(full[0]), .empty_o(empty[0]),
        .afull_o(afull[0]), .aempty_o(aempty[0]), .level_o(lvl_a), .ovf_o(ovf[0]), .udf_o(udf[0]));

    fifo_level_sync #(.DEPTH(8), .DATAW(8), .AFULL_LVL(6), .AEMPTY_LVL(2), .FWFT(1)) u_d8 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .we_i(we[1]), .dat_i(din[1]), .re_i(re[1]),
        .dat_o(dout[1]), .valid_o(valid[1]), .full_o(full[1]), .empty_o(empty[1]),
        .afull_o(afull[1]), .aempty_o(aempty[1]), .level_o(lvl_b), .ovf_o(ovf[1]), .udf_o(udf[1]));

    fifo_level_sync #(.DEPTH(4), .DATAW(8), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(0)) u_r4 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[2]), .we_i(we[2]), .dat_i(din[2]), .re_i(re[2]),
        .dat_o(dout[2]), .valid_o(valid[2]), .full_o(full[2]), .empty_o(empty[2]),
        .afull_o(afull[2]), .aempty_o(aempty[2]), .level_o(lvl_c), .ovf_o(ovf[2]), .udf_o(udf[2]));

    function automatic int dep_of(input int d);
        return (d == 1) ? 8 : 4;
    endfunction

    function automatic int af_of(input int d);
        return (d == 1) ? 6 : 3;
    endfunction

    function automatic int ae_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int lvl_of(input int d);
        case (d)
            0:       return int'(lvl_a);
            1:       return int'(lvl_b);
            default: return int'(lvl_c);
        endcase
    endfunction

    task automatic model_edge(input int d);
        int  n;
        bit  rd;
        bit  wr;
        n = mq[d].size();
        if (fl[d] === 1'b1) begin
            mq[d].delete();
            m_ovf[d] = 1'b0;
            m_udf[d] = 1'b0;
            m_val[d] = 1'b0;
            return;
        end
        rd = (re[d] === 1'b1) && (n > 0);
        wr = (we[d] === 1'b1) && ((n < dep_of(d)) || rd);
        if (we[d] === 1'b1 && !wr) m_ovf[d] = 1'b1;
        if (re[d] === 1'b1 && n == 0) m_udf[d] = 1'b1;
        m_val[d] = rd;
        if (rd) m_dat[d] = mq[d].pop_front();
        if (wr) mq[d].push_back(din[d]);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            m_ovf[d] = 1'b0;
            m_udf[d] = 1'b0;
            m_val[d] = 1'b0;
            m_dat[d] = 8'h00;
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            we[d]  = 1'b0;
            re[d]  = 1'b0;
            fl[d]  = 1'b0;
            din[d] = 8'h00;
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT saw, then settle.
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_edge(d);
        #2;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (lvl_of(d) != 0 || {full[d], empty[d], afull[d], aempty[d], ovf[d], udf[d], valid[d]} !== 7'b0101000) begin
                errors++;
                $display("FAIL reset_state dut%0d: level=%0d f/e/af/ae/ovf/udf/v=%b%b%b%b%b%b%b want level=0 0101000",
                         d, lvl_of(d), full[d], empty[d], afull[d], aempty[d], ovf[d], udf[d], valid[d]);
            end
        end
        checks++;
        if (dout[2] !== 8'h00) begin
            errors++;
            $display("FAIL reset_regdata: got %h want 00", dout[2]);
        end
        rst = 1'b0;
        model_reset();
        we[0] = 1'b1; din[0] = 8'h5A;
        cycle();
        idle();
        checks++;
        if (lvl_of(0) != 1 || dout[0] !== 8'h5A) begin
            errors++;
            $display("FAIL first_write: level=%0d data=%h want 1 5a", lvl_of(0), dout[0]);
        end
        fl[0] = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            we[0] = 1'b1; din[0] = 8'hA1 + 8'(i);
            cycle();
        end
        idle();
        checks++;
        if (full[0] !== 1'b1 || lvl_of(0) != 4 || ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL overflow: full=%b level=%0d ovf=%b want 1 4 1", full[0], lvl_of(0), ovf[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout[0] !== 8'hA1 + 8'(i)) begin
                errors++;
                $display("FAIL ovf_readback[%0d]: got %h want %h", i, dout[0], 8'hA1 + 8'(i));
            end
            re[0] = 1'b1;
            cycle();
        end
        idle();
        checks++;
        if (empty[0] !== 1'b1 || valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: empty=%b valid=%b want 1 0", empty[0], valid[0]);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            we[0] = 1'b1; din[0] = 8'hC0 + 8'(i);
            cycle();
        end
        idle();
        checks++;
        if (lvl_of(0) != 3 || ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: level=%0d ovf=%b want 3 1", lvl_of(0), ovf[0]);
        end
        fl[0] = 1'b1; we[0] = 1'b1; re[0] = 1'b1; din[0] = 8'hEE;
        cycle();
        idle();
        checks++;
        if (lvl_of(0) != 0 || empty[0] !== 1'b1 || ovf[0] !== 1'b0 || udf[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush: level=%0d empty=%b ovf=%b udf=%b want 0 1 0 0", lvl_of(0), empty[0], ovf[0], udf[0]);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) begin
            we[0] = 1'b1; din[0] = 8'hB0 + 8'(i);
            cycle();
        end
        we[0] = 1'b1; re[0] = 1'b1; din[0] = 8'h55;
        cycle();
        idle();
        checks++;
        if (lvl_of(0) != 4 || ovf[0] !== 1'b0 || dout[0] !== 8'hB1) begin
            errors++;
            $display("FAIL full_rw: level=%0d ovf=%b head=%h want 4 0 b1", lvl_of(0), ovf[0], dout[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout[0] !== ((i == 3) ? 8'h55 : 8'hB1 + 8'(i))) begin
                errors++;
                $display("FAIL full_rw_read[%0d]: got %h want %h", i, dout[0], (i == 3) ? 8'h55 : 8'hB1 + 8'(i));
            end
            re[0] = 1'b1;
            cycle();
        end
        idle();
    endtask

    task automatic test_empty_rw();
        re[0] = 1'b1; we[0] = 1'b1; din[0] = 8'h3C;
        cycle();
        idle();
        checks++;
        if (udf[0] !== 1'b1 || lvl_of(0) != 1 || dout[0] !== 8'h3C) begin
            errors++;
            $display("FAIL empty_rw: udf=%b level=%0d head=%h want 1 1 3c", udf[0], lvl_of(0), dout[0]);
        end
        re[0] = 1'b1;
        cycle();
        idle();
        checks++;
        if (empty[0] !== 1'b1 || udf[0] !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw_drain: empty=%b udf=%b want 1 1", empty[0], udf[0]);
        end
    endtask

    task automatic test_thresholds();
        for (int i = 1; i <= 8; i++) begin
            we[1] = 1'b1; din[1] = 8'h10 + 8'(i);
            cycle();
            idle();
            checks++;
            if (lvl_of(1) != i || aempty[1] !== (i <= 2) || afull[1] !== (i >= 6) || full[1] !== (i == 8)) begin
                errors++;
                $display("FAIL thresholds lvl%0d: level=%0d ae=%b af=%b full=%b want ae=%b af=%b full=%b",
                         i, lvl_of(1), aempty[1], afull[1], full[1], i <= 2, i >= 6, i == 8);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (dout[1] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL threshold_drain[%0d]: got %h want %h", i, dout[1], 8'h10 + 8'(i));
            end
            re[1] = 1'b1;
            cycle();
        end
        idle();
    endtask

    task automatic test_stream();
        logic [7:0] log_q [$];
        int         rd_idx;
        rd_idx = 0;
        for (int i = 0; i < 22; i++) begin
            we[1] = (i < 20);
            din[1] = 8'($urandom);
            re[1] = (i >= 2);
            if (we[1]) log_q.push_back(din[1]);
            if (re[1] && mq[1].size() > 0) begin
                checks++;
                if (dout[1] !== log_q[rd_idx]) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: got %h want %h", rd_idx, dout[1], log_q[rd_idx]);
                end
                rd_idx++;
            end
            cycle();
        end
        idle();
        checks++;
        if (rd_idx != 20 || empty[1] !== 1'b1 || ovf[1] !== 1'b0 || udf[1] !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: reads=%0d empty=%b ovf=%b udf=%b want 20 1 0 0", rd_idx, empty[1], ovf[1], udf[1]);
        end
    endtask

    task automatic test_registered_read();
        we[2] = 1'b1; din[2] = 8'h11;
        cycle();
        din[2] = 8'h22;
        cycle();
        idle();
        checks++;
        if (valid[2] !== 1'b0 || dout[2] !== 8'h00) begin
            errors++;
            $display("FAIL reg_before_read: valid=%b data=%h want 0 00", valid[2], dout[2]);
        end
        re[2] = 1'b1;
        cycle();
        checks++;
        if (valid[2] !== 1'b1 || dout[2] !== 8'h11) begin
            errors++;
            $display("FAIL reg_read1: valid=%b data=%h want 1 11", valid[2], dout[2]);
        end
        cycle();
        idle();
        checks++;
        if (valid[2] !== 1'b1 || dout[2] !== 8'h22) begin
            errors++;
            $display("FAIL reg_read2: valid=%b data=%h want 1 22", valid[2], dout[2]);
        end
        cycle();
        checks++;
        if (valid[2] !== 1'b0 || dout[2] !== 8'h22) begin
            errors++;
            $display("FAIL reg_hold: valid=%b data=%h want 0 22", valid[2], dout[2]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                we[d]  = ($urandom_range(0, 9) < 6);
                re[d]  = ($urandom_range(0, 9) < 5);
                fl[d]  = ($urandom_range(0, 49) == 0);
                din[d] = 8'($urandom);
            end
            cycle();
            for (int d = 0; d < 3; d++) begin
                int n;
                n = mq[d].size();
                checks++;
                if (lvl_of(d) != n) begin
                    errors++;
                    $display("FAIL rnd_level dut%0d cyc%0d: got %0d want %0d", d, c, lvl_of(d), n);
                end
                checks++;
                if ({full[d], empty[d], afull[d], aempty[d]} !== {n == dep_of(d), n == 0, n >= af_of(d), n <= ae_of(d)}) begin
                    errors++;
                    $display("FAIL rnd_flags dut%0d cyc%0d: f/e/af/ae=%b%b%b%b level_model=%0d", d, c,
                             full[d], empty[d], afull[d], aempty[d], n);
                end
                checks++;
                if (ovf[d] !== m_ovf[d] || udf[d] !== m_udf[d]) begin
                    errors++;
                    $display("FAIL rnd_err dut%0d cyc%0d: ovf=%b udf=%b want %b %b", d, c, ovf[d], udf[d], m_ovf[d], m_udf[d]);
                end
                checks++;
                if (d == 2) begin
                    if (valid[2] !== m_val[2] || dout[2] !== m_dat[2]) begin
                        errors++;
                        $display("FAIL rnd_regread cyc%0d: valid=%b data=%h want %b %h", c, valid[2], dout[2], m_val[2], m_dat[2]);
                    end
                end else if (valid[d] !== (n > 0) || (n > 0 && dout[d] !== mq[d][0])) begin
                    errors++;
                    $display("FAIL rnd_head dut%0d cyc%0d: valid=%b data=%h want valid=%b", d, c, valid[d], dout[d], n > 0);
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        for (int d = 0; d < 3; d++) fl[d] = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            we[0] = 1'b1; din[0] = 8'h90 + 8'(i);
            we[1] = 1'b1; din[1] = 8'h70 + 8'(i);
            we[2] = (i < 2); re[2] = (i == 2); din[2] = 8'h99;
            cycle();
        end
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (lvl_of(d) != 0 || {full[d], empty[d], afull[d], aempty[d], ovf[d], udf[d], valid[d]} !== 7'b0101000) begin
                errors++;
                $display("FAIL async_reset dut%0d: level=%0d f/e/af/ae/ovf/udf/v=%b%b%b%b%b%b%b want level=0 0101000",
                         d, lvl_of(d), full[d], empty[d], afull[d], aempty[d], ovf[d], udf[d], valid[d]);
            end
        end
        checks++;
        if (dout[2] !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_regdata: got %h want 00", dout[2]);
        end
        idle();
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        we[1] = 1'b1; din[1] = 8'h42;
        cycle();
        idle();
        checks++;
        if (lvl_of(1) != 1 || dout[1] !== 8'h42) begin
            errors++;
            $display("FAIL post_reset_write: level=%0d data=%h want 1 42", lvl_of(1), dout[1]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overflow();
        test_flush();
        test_full_rw();
        test_empty_rw();
        test_thresholds();
        test_stream();
        test_registered_read();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
